riscv_hwloop_jump_ctrl: RTL and testbench

- Consumer of the hardware-loop register file outputs: start, end and counter per loop.
- Watches the PC of the instruction in ID. When that instruction is a loop's end instruction:
  - drives the one-hot counter-decrement vector back to the loop registers;
  - issues a registered jump request to the fetch stage, targeting the loop start.
- Sits between the ID stage, the hwloop register file and the prefetch/PC-mux logic.
- Resolves nested loops by priority and holds the jump until fetch accepts it.

---
 rtl/riscv_hwloop_jump_ctrl_pkg.sv | 26 ++
 rtl/riscv_hwloop_jump_ctrl_if.sv | 30 +++
 rtl/riscv_hwloop_jump_ctrl_match.sv | 48 ++++
 rtl/riscv_hwloop_jump_ctrl.sv | 116 +++++++++++
 tb/tb_riscv_hwloop_jump_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_hwloop_jump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_hwloop_pkg
// Purpose  : Shared types and constants for the hardware-loop jump controller
//            (loop-controller state encoding, default loop count, bit
//            positions of the loop-register write strobes).
// Revision : 1.0 - initial release
// ============================================================================
package riscv_hwloop_pkg;

  // Default number of hardware-loop register sets (index 0 = innermost)
  localparam int HWLP_N_REGS = 2;

  // Bit positions inside the 3-bit loop-register write strobe from EX
  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

  // Jump controller state: IDLE watches the ID PC, PEND holds a jump request
  typedef enum logic [0:0] {
    HWLP_IDLE = 1'b0,
    HWLP_PEND = 1'b1
  } hwlp_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_hwloop_jump_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_hwloop_jump_ctrl_if
// Purpose  : Jump handshake between the hwloop jump controller (master) and
//            the prefetch / PC-mux logic (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_hwloop_jump_ctrl_if;

  logic        jump_req_o;     // jump to hwloop start requested
  logic [31:0] jump_target_o;  // start address to fetch
  logic        busy_o;         // jump pending, ID must hold the next instruction
  logic        jump_ack_i;     // fetch accepted the jump target

  modport master (
    output jump_req_o,
    output jump_target_o,
    output busy_o,
    input  jump_ack_i
  );

  modport slave (
    input  jump_req_o,
    input  jump_target_o,
    input  busy_o,
    output jump_ack_i
  );

endinterface
`default_nettype wire

// File: rtl/riscv_hwloop_jump_ctrl_match.sv
`default_nettype none
// ============================================================================
// Module   : riscv_hwloop_match
// Purpose  : Per-loop end-address comparators and a fixed-priority encoder.
//            The lowest-index active loop whose end address equals the ID PC
//            wins; a loop with a zero counter is inactive and never matches.
//            take is raised when the decrement is allowed and more than one
//            iteration remains (counter == 1 is the fall-through iteration).
// Revision : 1.0 - initial release
// ============================================================================
module riscv_hwloop_match #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic [31:0]                current_pc_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_counter_i,
  input  logic                       dec_allowed_i,
  output logic                       match_valid_o,
  output logic [N_REG_BITS-1:0]      sel_o,
  output logic                       take_o
);

  logic [N_REGS-1:0] w_match;

  genvar k;
  for (k = 0; k < N_REGS; k++) begin : g_match
    assign w_match[k] = (current_pc_i == hwlp_end_addr_i[k]) &&
                        (hwlp_counter_i[k] != 32'd0);
  end

  // Priority encoder: scan from outermost down so the innermost match wins
  always_comb begin
    match_valid_o = 1'b0;
    sel_o         = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        match_valid_o = 1'b1;
        sel_o         = i[N_REG_BITS-1:0];
      end
    end
  end

  assign take_o = match_valid_o && dec_allowed_i &&
                  (hwlp_counter_i[sel_o] > 32'd1);

endmodule
`default_nettype wire

// File: rtl/riscv_hwloop_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_hwloop_jump_ctrl
// Purpose  : Watches the PC in ID against the hardware-loop end addresses.
//            On a committing end instruction it pulses a one-hot counter
//            decrement and, if iterations remain, requests a jump to the loop
//            start which is held until fetch accepts it, a flush kills it or
//            the pending loop is reprogrammed.
// Options  : RISCV_HWLP_BYPASS_EN - present the jump request and target
//            combinationally in the detection cycle (zero-latency jump).
// Revision : 1.0 - initial release
// ============================================================================
module riscv_hwloop_jump_ctrl
  import riscv_hwloop_pkg::*;
#(
  parameter int N_REGS     = HWLP_N_REGS,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                current_pc_i,
  input  logic                       pc_valid_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_counter_i,
  input  logic [2:0]                 hwlp_we_i,
  input  logic [N_REG_BITS-1:0]      hwlp_regid_i,
  input  logic                       flush_i,
  output logic [N_REGS-1:0]          hwlp_dec_cnt_o,
  riscv_hwloop_jump_ctrl_if.master   fetch_if
);

  hwlp_state_e             r_state;
  logic                    r_jump_req;
  logic                    r_busy;
  logic [31:0]             r_target;
  logic [N_REG_BITS-1:0]   r_pend_id;

  logic                    w_dec_allowed;
  logic                    w_match_valid;
  logic [N_REG_BITS-1:0]   w_sel;
  logic                    w_take;
  logic                    w_cancel;

  // Only a committing, unflushed instruction seen while idle may count
  assign w_dec_allowed = (r_state == HWLP_IDLE) && pc_valid_i && !flush_i;

  // Reprogramming the loop we are about to jump into invalidates the jump
  assign w_cancel = (hwlp_we_i != 3'b000) && (hwlp_regid_i == r_pend_id);

  riscv_hwloop_match #(
    .N_REGS     (N_REGS),
    .N_REG_BITS (N_REG_BITS)
  ) u_match (
    .current_pc_i    (current_pc_i),
    .hwlp_end_addr_i (hwlp_end_addr_i),
    .hwlp_counter_i  (hwlp_counter_i),
    .dec_allowed_i   (w_dec_allowed),
    .match_valid_o   (w_match_valid),
    .sel_o           (w_sel),
    .take_o          (w_take)
  );

  // One-hot decrement for the selected loop in the detection cycle
  always_comb begin
    hwlp_dec_cnt_o = '0;
    if (w_match_valid && w_dec_allowed) begin
      hwlp_dec_cnt_o[w_sel] = 1'b1;
    end
  end

  // Jump FSM with registered request/busy/target; flush wins over ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HWLP_IDLE;
      r_jump_req <= 1'b0;
      r_busy     <= 1'b0;
      r_target   <= 32'd0;
      r_pend_id  <= '0;
    end else if (r_state == HWLP_IDLE) begin
      if (w_take) begin
        r_target  <= hwlp_start_addr_i[w_sel];
        r_pend_id <= w_sel;
`ifdef RISCV_HWLP_BYPASS_EN
        // Fetch may already have taken the bypassed target this cycle
        if (!fetch_if.jump_ack_i) begin
          r_state    <= HWLP_PEND;
          r_jump_req <= 1'b1;
          r_busy     <= 1'b1;
        end
`else
        r_state    <= HWLP_PEND;
        r_jump_req <= 1'b1;
        r_busy     <= 1'b1;
`endif
      end
    end else begin
      if (flush_i || fetch_if.jump_ack_i || w_cancel) begin
        r_state    <= HWLP_IDLE;
        r_jump_req <= 1'b0;
        r_busy     <= 1'b0;
      end
    end
  end

`ifdef RISCV_HWLP_BYPASS_EN
  assign fetch_if.jump_req_o    = r_jump_req | w_take;
  assign fetch_if.jump_target_o = w_take ? hwlp_start_addr_i[w_sel] : r_target;
`else
  assign fetch_if.jump_req_o    = r_jump_req;
  assign fetch_if.jump_target_o = r_target;
`endif
  assign fetch_if.busy_o = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_riscv_hwloop_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_hwloop_jump_ctrl
// Purpose  : Self-checking bench. The bench plays the loop register file and
//            keeps a transaction-level model of the controller; expected
//            decrement and jump-request events are queued with their cycle
//            number and a negedge monitor matches them against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_hwloop_jump_ctrl;

  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]         pc;
  logic                valid;
  logic                flush;
  logic [NR-1:0][31:0] rf_start;
  logic [NR-1:0][31:0] rf_end;
  logic [NR-1:0][31:0] rf_cnt;
  logic [2:0]          we;
  logic [0:0]          rid;
  logic [NR-1:0]       dec;

  riscv_hwloop_jump_ctrl_if fif ();

  riscv_hwloop_jump_ctrl #(.N_REGS(NR), .N_REG_BITS(1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .current_pc_i      (pc),
    .pc_valid_i        (valid),
    .hwlp_start_addr_i (rf_start),
    .hwlp_end_addr_i   (rf_end),
    .hwlp_counter_i    (rf_cnt),
    .hwlp_we_i         (we),
    .hwlp_regid_i      (rid),
    .flush_i           (flush),
    .hwlp_dec_cnt_o    (dec),
    .fetch_if          (fif)
  );

  typedef struct { int cyc; logic [NR-1:0] vec; } dec_t;
  typedef struct { int cyc; logic [31:0] tgt; logic busy; } jmp_t;

  dec_t dq[$];
  jmp_t jq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Transaction-level model: is a jump outstanding, to where, for which loop
  bit          m_pend = 1'b0;
  logic [31:0] m_tgt  = 32'd0;
  int          m_id   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_loop(input int k, input logic [31:0] s, input logic [31:0] e,
                          input logic [31:0] c);
    rf_start[k] = s;
    rf_end[k]   = e;
    rf_cnt[k]   = c;
  endtask

  // Apply one cycle of stimulus, queue the model's expectations, advance
  task automatic drive_cycle(input logic [31:0] p, input logic v, input logic f,
                             input logic a, input logic [2:0] w, input logic [0:0] r,
                             input logic [31:0] ws, input logic [31:0] wend,
                             input logic [31:0] wc);
    int            sel;
    logic [NR-1:0] dv;
    dec_t          de;
    jmp_t          je;
    pc = p; valid = v; flush = f; fif.jump_ack_i = a; we = w; rid = r;
    sel = -1;
    dv  = '0;
    for (int k = 0; k < NR; k++)
      if (sel < 0 && p == rf_end[k] && rf_cnt[k] != 32'd0) sel = k;
    if (m_pend) begin
      je.cyc = cyc; je.tgt = m_tgt; je.busy = 1'b1;
      jq.push_back(je);
      if (f || a || (w != 3'b000 && int'(r) == m_id)) m_pend = 1'b0;
    end else if (sel >= 0 && v && !f) begin
      dv[sel] = 1'b1;
      de.cyc = cyc; de.vec = dv;
      dq.push_back(de);
      if (rf_cnt[sel] > 32'd1) begin
`ifdef RISCV_HWLP_BYPASS_EN
        je.cyc = cyc; je.tgt = rf_start[sel]; je.busy = 1'b0;
        jq.push_back(je);
        if (!a) begin
          m_pend = 1'b1; m_tgt = rf_start[sel]; m_id = sel;
        end
`else
        m_pend = 1'b1; m_tgt = rf_start[sel]; m_id = sel;
`endif
      end
    end
    @(posedge clk);
    #1;
    // Register file: a write to a loop beats its decrement
    for (int k = 0; k < NR; k++) begin
      if (w != 3'b000 && int'(r) == k) begin
        if (w[0]) rf_start[k] = ws;
        if (w[1]) rf_end[k]   = wend;
        if (w[2]) rf_cnt[k]   = wc;
      end else if (dv[k]) begin
        rf_cnt[k] = rf_cnt[k] - 32'd1;
      end
    end
    cyc++;
  endtask

  task automatic step(input logic [31:0] p, input logic v, input logic f, input logic a);
    drive_cycle(p, v, f, a, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  // Monitor: every cycle, pair DUT events with queued expectations
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (dq.size() > 0 && dq[0].cyc < cyc) begin
          checks++; errors++;
          $display("FAIL dec_missed cycle=%0d actual=none required=%b", dq[0].cyc, dq[0].vec);
          dq.delete(0);
        end
        while (jq.size() > 0 && jq[0].cyc < cyc) begin
          checks++; errors++;
          $display("FAIL jump_missed cycle=%0d actual=none required=%h", jq[0].cyc, jq[0].tgt);
          jq.delete(0);
        end
        if (dec != '0) begin
          checks++;
          if (dq.size() > 0 && dq[0].cyc == cyc) begin
            if (dec !== dq[0].vec) begin
              errors++;
              $display("FAIL dec_vec cycle=%0d actual=%b required=%b", cyc, dec, dq[0].vec);
            end
            dq.delete(0);
          end else begin
            errors++;
            $display("FAIL dec_spurious cycle=%0d actual=%b required=00", cyc, dec);
          end
        end else if (dq.size() > 0 && dq[0].cyc == cyc) begin
          checks++; errors++;
          $display("FAIL dec_missed cycle=%0d actual=00 required=%b", cyc, dq[0].vec);
          dq.delete(0);
        end
        if (fif.jump_req_o) begin
          checks++;
          if (jq.size() > 0 && jq[0].cyc == cyc) begin
            if (fif.jump_target_o !== jq[0].tgt || fif.busy_o !== jq[0].busy) begin
              errors++;
              $display("FAIL jump_req cycle=%0d actual tgt=%h busy=%b required tgt=%h busy=%b",
                       cyc, fif.jump_target_o, fif.busy_o, jq[0].tgt, jq[0].busy);
            end
            jq.delete(0);
          end else begin
            errors++;
            $display("FAIL jump_spurious cycle=%0d actual tgt=%h required=no request", cyc,
                     fif.jump_target_o);
          end
        end else if (jq.size() > 0 && jq[0].cyc == cyc) begin
          checks++; errors++;
          $display("FAIL jump_missed cycle=%0d actual=no request required=%h", cyc, jq[0].tgt);
          jq.delete(0);
        end
      end
    end
  end

  initial begin
    int          r;
    logic [31:0] p;
    rst_n = 1'b0; pc = 32'd0; valid = 1'b0; flush = 1'b0; we = 3'b000; rid = 1'b0;
    fif.jump_ack_i = 1'b0;
    rf_start = '0; rf_end = '0; rf_cnt = '0;
    #12;
    chk("reset_dec",    32'(dec), 32'd0);
    chk("reset_req",    32'(fif.jump_req_o), 32'd0);
    chk("reset_target", fif.jump_target_o, 32'd0);
    chk("reset_busy",   32'(fif.busy_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single loop, three iterations: jump, jump, fall through, then inactive
    set_loop(0, 32'h100, 32'h10C, 32'd3);
    set_loop(1, 32'h800, 32'h900, 32'd0);
    for (int i = 0; i < 6; i++) step(32'h10C, 1'b1, 1'b0, 1'b1);

    // Nested loops sharing an end address: innermost wins
    set_loop(0, 32'h200, 32'h120, 32'd2);
    set_loop(1, 32'h300, 32'h120, 32'd5);
    step(32'h120, 1'b1, 1'b0, 1'b0);
    step(32'h124, 1'b1, 1'b0, 1'b1);

    // Stall on the end address: only the committing cycle counts
    set_loop(0, 32'h100, 32'h10C, 32'd3);
    set_loop(1, 32'h800, 32'h900, 32'd0);
    for (int i = 0; i < 4; i++) step(32'h10C, 1'b0, 1'b0, 1'b0);
    step(32'h10C, 1'b1, 1'b0, 1'b0);
    step(32'h10C, 1'b0, 1'b0, 1'b1);
    step(32'h110, 1'b1, 1'b0, 1'b0);

    // Held request while fetch withholds the ack
    set_loop(0, 32'h100, 32'h10C, 32'd4);
    step(32'h10C, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(32'h10C, 1'b1, 1'b0, 1'b0);
    step(32'h10C, 1'b1, 1'b0, 1'b1);
    step(32'h100, 1'b1, 1'b0, 1'b0);

    // Flush and ack together kill the jump
    set_loop(0, 32'h100, 32'h10C, 32'd4);
    step(32'h10C, 1'b1, 1'b0, 1'b0);
    step(32'h104, 1'b1, 1'b1, 1'b1);
    step(32'h108, 1'b1, 1'b0, 1'b0);

    // Write to another loop keeps the jump; write to the pending loop drops it
    set_loop(0, 32'h500, 32'h50C, 32'd4);
    step(32'h50C, 1'b1, 1'b0, 1'b0);
    drive_cycle(32'h510, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 32'h600, 32'h0, 32'h0);
    drive_cycle(32'h510, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 32'd7);
    step(32'h514, 1'b1, 1'b0, 1'b0);

    // Randomised traffic over a small address pool so nesting is frequent
    set_loop(0, 32'h10, 32'h44, 32'd3);
    set_loop(1, 32'h20, 32'h44, 32'd4);
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      p = rf_end[0];
      else if (r < 7) p = rf_end[1];
      else            p = 32'h40 + 32'(4 * $urandom_range(0, 3));
      drive_cycle(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                  1'($urandom_range(0, 1)), 32'(16 * $urandom_range(1, 3)),
                  32'h40 + 32'(4 * $urandom_range(0, 2)), 32'($urandom_range(0, 5)));
    end

    // Asynchronous reset in the middle of a pending jump
    step(32'hFFFF_0000, 1'b0, 1'b0, 1'b1);
    step(32'hFFFF_0000, 1'b0, 1'b0, 1'b1);
    set_loop(0, 32'h100, 32'h10C, 32'd4);
    set_loop(1, 32'h800, 32'h900, 32'd0);
    step(32'h10C, 1'b1, 1'b0, 1'b0);
    valid = 1'b0; pc = 32'h0;
    #1;
    chk("pend_req",    32'(fif.jump_req_o), 32'd1);
    chk("pend_busy",   32'(fif.busy_o), 32'd1);
    chk("pend_target", fif.jump_target_o, 32'h100);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",    32'(fif.jump_req_o), 32'd0);
    chk("async_rst_busy",   32'(fif.busy_o), 32'd0);
    chk("async_rst_target", fif.jump_target_o, 32'd0);
    chk("async_rst_dec",    32'(dec), 32'd0);
    m_pend = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b0, 1'b0);

    chk("dec_queue_drained",  32'(dq.size()), 32'd0);
    chk("jump_queue_drained", 32'(jq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
